// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses must be word aligned.
  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus bundle: pc register block, redirect/stall from the pipeline,
// instruction memory port and the IF/ID buffer outputs.
interface fetch_if;

  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;

  // The fetch controller side.
  modport master (
    input  pc, stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    output pc_write, next_pc, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_err
  );

  // The environment: pc register block, pipeline and instruction memory.
  modport slave (
    output pc, stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    input  pc_write, next_pc, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_err
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one outstanding memory request at a
// time, fills the IF/ID buffer, handles redirects, and traps on timeout or a
// misaligned redirect target.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | one quiet cycle after reset, no request
//   REQ   | fetching from pc; responses fill the IF/ID buffer
//   DRAIN | waiting out a request abandoned by a redirect; response dropped
//   ERR   | sticky fault; only reset leaves
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_e     state_q;
  logic             if_valid_q;
  logic [31:0]      if_instr_q;
  logic [31:0]      if_pc_q;
  logic [31:0]      drain_addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             fetch_err_q;

  logic        req;
  logic [31:0] addr;
  logic        pc_wr;
  logic [31:0] npc;
  logic        redir_ok;
  logic        redir_bad;
  logic        accept;
  logic        unanswered;
  logic        consume;
  logic        timeout_hit;

  assign redir_ok    = bus.redirect_valid && !pc_misaligned(bus.redirect_pc);
  assign redir_bad   = bus.redirect_valid &&  pc_misaligned(bus.redirect_pc);
  assign accept      = req && bus.imem_ready;
  assign unanswered  = req && !bus.imem_ready;
  assign consume     = if_valid_q && !bus.stall;
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = unanswered && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  // Request and pc-update decode; reset silences both immediately.
  // A request raised in REQ always sees an empty buffer on the following
  // cycle (it was empty or got consumed), so it stays up until answered.
  always_comb begin
    req   = 1'b0;
    addr  = bus.pc;
    pc_wr = 1'b0;
    npc   = bus.pc;
    if (!reset) begin
      unique case (state_q)
        REQ:     req = !if_valid_q || !bus.stall;
        DRAIN: begin
          req  = 1'b1;
          addr = drain_addr_q;
        end
        default: ;
      endcase
      if (state_q != ERR && redir_ok) begin
        pc_wr = 1'b1;
        npc   = bus.redirect_pc;
      end else if (state_q == REQ && !bus.redirect_valid && accept) begin
        pc_wr = 1'b1;
        npc   = bus.pc + PC_STEP;
      end
    end
  end

  // FSM, IF/ID buffer, drain address, timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      drain_addr_q <= '0;
      cnt_q        <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redir_bad) begin
            state_q     <= ERR;
            fetch_err_q <= 1'b1;
            if_valid_q  <= 1'b0;
          end else begin
            state_q <= REQ;
            if (bus.redirect_valid) if_valid_q <= 1'b0;
          end
        end
        REQ, DRAIN: begin
          if (bus.redirect_valid) begin
            cnt_q      <= '0;
            if_valid_q <= 1'b0;
            if (redir_bad) begin
              state_q     <= ERR;
              fetch_err_q <= 1'b1;
            end else if (state_q == REQ && unanswered) begin
              drain_addr_q <= bus.pc;
              state_q      <= DRAIN;
            end else if (state_q == DRAIN && bus.imem_ready) begin
              // The abandoned response arrived this cycle; nothing left to drain.
              state_q <= REQ;
            end
          end else if (accept) begin
            cnt_q <= '0;
            if (state_q == REQ) begin
              if_valid_q <= 1'b1;
              if_instr_q <= bus.imem_rdata;
              if_pc_q    <= bus.pc;
            end else begin
              state_q <= REQ;
              if (consume) if_valid_q <= 1'b0;
            end
          end else begin
            if (consume) if_valid_q <= 1'b0;
            if (timeout_hit) begin
              state_q     <= ERR;
              fetch_err_q <= 1'b1;
              if_valid_q  <= 1'b0;
            end else if (unanswered) begin
              cnt_q <= cnt_d;
            end
          end
        end
        ERR: begin
          fetch_err_q <= 1'b1;
          if_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.pc_write  = pc_wr;
  assign bus.next_pc   = npc;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: pc register and wait-state memory models around the
// DUT, directed scenarios plus a randomized run against an instruction-stream
// scoreboard.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int unsigned TO      = 8;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  fetch_if bus ();

  fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // pc register block and a memory answering after mem_lat wait cycles
  logic [31:0] pc_q = '0;
  int unsigned mem_lat = 0;
  int unsigned mem_wait = 0;
  logic        mem_off = 1'b0;

  always @(posedge clk) begin
    if (reset) pc_q <= '0;
    else if (bus.pc_write) pc_q <= bus.next_pc;
    if (reset || !bus.imem_req || bus.imem_ready) mem_wait <= 0;
    else mem_wait <= mem_wait + 1;
  end

  assign bus.pc         = pc_q;
  assign bus.imem_ready = bus.imem_req && !mem_off && (mem_wait >= mem_lat);
  assign bus.imem_rdata = bus.imem_addr ^ XOR_PAT;

  // Leaves the bench in the first post-reset cycle (controller in IDLE).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.redirect_valid = 1'b0; bus.stall = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_off = 1'b0; mem_lat = 3;
    do_reset(); #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_idle_req: got %b want 0", bus.imem_req); end
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_req: req %b addr %h want 1 0", bus.imem_req, bus.imem_addr); end
    reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; bus.stall = 1'b1; #1;
    n_cmp++; if (bus.imem_req !== 1'b0 || bus.pc_write !== 1'b0) begin n_bad++; $display("FAIL rst_override: req %b pc_write %b want 0 0", bus.imem_req, bus.pc_write); end
    n_cmp++; if (bus.next_pc !== 32'h0) begin n_bad++; $display("FAIL rst_next_pc: got %h want 0", bus.next_pc); end
    @(negedge clk); #1;
    n_cmp++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL rst_regs: if_valid %b if_pc %h err %b want 0 0 0", bus.if_valid, bus.if_pc, bus.fetch_err); end
    n_cmp++; if (bus.if_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_nop: got %h want 00000013", bus.if_instr); end
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    mem_off = 1'b0; mem_lat = 0;
    do_reset(); #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL zw_idle: req %b want 0", bus.imem_req); end
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.pc_write !== 1'b1 || bus.next_pc !== 32'h4) begin n_bad++; $display("FAIL zw_first: req %b pc_write %b next %h want 1 1 4", bus.imem_req, bus.pc_write, bus.next_pc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      e = 32'(4 * k);
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== e || bus.if_instr !== (e ^ XOR_PAT)) begin n_bad++; $display("FAIL zw_seq%0d: valid %b pc %h instr %h want 1 %h %h", k, bus.if_valid, bus.if_pc, bus.if_instr, e, e ^ XOR_PAT); end
    end
  endtask

  task automatic test_wait_states();
    int t = 0;
    int writes = 0;
    mem_off = 1'b0; mem_lat = 3;
    do_reset();
    @(negedge clk); #1;
    while (!bus.if_valid && t < 30) begin @(negedge clk); #1; t++; end
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin n_bad++; $display("FAIL ws_first_fill: valid %b pc %h want 1 0", bus.if_valid, bus.if_pc); return; end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (bus.pc_write) writes++;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL ws_hold%0d: req %b addr %h want 1 4", i, bus.imem_req, bus.imem_addr); end
      n_cmp++; if (bus.if_valid !== (i == 0)) begin n_bad++; $display("FAIL ws_valid%0d: got %b want %b", i, bus.if_valid, (i == 0)); end
    end
    @(negedge clk); #1;
    n_cmp++; if (writes != 1) begin n_bad++; $display("FAIL ws_pc_writes: got %0d want 1", writes); end
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin n_bad++; $display("FAIL ws_second_fill: valid %b pc %h want 1 4", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_stall();
    int t = 0;
    mem_off = 1'b0; mem_lat = 0;
    do_reset();
    @(negedge clk); #1;
    while (!(bus.if_valid && bus.if_pc == 32'h8) && t < 30) begin @(negedge clk); #1; t++; end
    n_cmp++; if (bus.if_pc !== 32'h8) begin n_bad++; $display("FAIL st_reach: if_pc %h want 8", bus.if_pc); return; end
    bus.stall = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.if_instr !== (32'h8 ^ XOR_PAT)) begin n_bad++; $display("FAIL st_hold%0d: valid %b pc %h instr %h want 1 8 %h", i, bus.if_valid, bus.if_pc, bus.if_instr, 32'h8 ^ XOR_PAT); end
      n_cmp++; if (bus.imem_req !== 1'b0 || bus.pc_write !== 1'b0) begin n_bad++; $display("FAIL st_quiet%0d: req %b pc_write %b want 0 0", i, bus.imem_req, bus.pc_write); end
    end
    @(negedge clk); bus.stall = 1'b0; #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC || bus.pc_write !== 1'b1 || bus.next_pc !== 32'h10) begin n_bad++; $display("FAIL st_release: req %b addr %h wr %b next %h want 1 c 1 10", bus.imem_req, bus.imem_addr, bus.pc_write, bus.next_pc); end
    @(negedge clk); #1;
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC) begin n_bad++; $display("FAIL st_next: valid %b pc %h want 1 c", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_redirect_drain();
    int t = 0;
    mem_off = 1'b0; mem_lat = 3;
    do_reset();
    @(negedge clk); #1;
    while (!(bus.imem_req && bus.imem_addr == 32'h10) && t < 60) begin @(negedge clk); #1; t++; end
    n_cmp++; if (bus.imem_addr !== 32'h10) begin n_bad++; $display("FAIL rd_reach: addr %h want 10", bus.imem_addr); return; end
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
    n_cmp++; if (bus.imem_ready !== 1'b0 || bus.pc_write !== 1'b1 || bus.next_pc !== 32'h100) begin n_bad++; $display("FAIL rd_redirect: ready %b wr %b next %h want 0 1 100", bus.imem_ready, bus.pc_write, bus.next_pc); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.pc_write !== 1'b0 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rd_drain: req %b addr %h wr %b valid %b want 1 10 0 0", bus.imem_req, bus.imem_addr, bus.pc_write, bus.if_valid); end
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_ready !== 1'b1 || bus.imem_addr !== 32'h10 || bus.pc_write !== 1'b0) begin n_bad++; $display("FAIL rd_drop: ready %b addr %h wr %b want 1 10 0", bus.imem_ready, bus.imem_addr, bus.pc_write); end
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rd_refetch: req %b addr %h valid %b want 1 100 0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    t = 0;
    while (!bus.if_valid && t < 20) begin @(negedge clk); #1; t++; end
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== (32'h100 ^ XOR_PAT)) begin n_bad++; $display("FAIL rd_fill: valid %b pc %h instr %h want 1 100 %h", bus.if_valid, bus.if_pc, bus.if_instr, 32'h100 ^ XOR_PAT); end
  endtask

  task automatic test_timeout();
    mem_off = 1'b1; mem_lat = 0;
    do_reset();
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d: req %b err %b want 1 0", i, bus.imem_req, bus.fetch_err); end
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL to_err: err %b req %b valid %b want 1 0 0", bus.fetch_err, bus.imem_req, bus.if_valid); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; #1;
    n_cmp++; if (bus.pc_write !== 1'b0 || bus.next_pc !== pc_q) begin n_bad++; $display("FAIL to_err_redirect: wr %b next %h want 0 %h", bus.pc_write, bus.next_pc, pc_q); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL to_sticky: err %b req %b want 1 0", bus.fetch_err, bus.imem_req); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL to_reset_clear: err %b want 0", bus.fetch_err); end
    // misaligned redirect target
    mem_off = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102; #1;
    n_cmp++; if (bus.pc_write !== 1'b0 || bus.next_pc !== pc_q) begin n_bad++; $display("FAIL mis_no_write: wr %b next %h want 0 %h", bus.pc_write, bus.next_pc, pc_q); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL mis_err: err %b req %b valid %b want 1 0 0", bus.fetch_err, bus.imem_req, bus.if_valid); end
  endtask

  task automatic test_wrap();
    mem_off = 1'b0; mem_lat = 0;
    do_reset();
    @(negedge clk);
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
    n_cmp++; if (bus.imem_ready !== 1'b1 || bus.pc_write !== 1'b1 || bus.next_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_coincide: ready %b wr %b next %h want 1 1 fffffffc", bus.imem_ready, bus.pc_write, bus.next_pc); end
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_discard: valid %b addr %h want 0 fffffffc", bus.if_valid, bus.imem_addr); end
    n_cmp++; if (bus.pc_write !== 1'b1 || bus.next_pc !== 32'h0) begin n_bad++; $display("FAIL wr_wrap: wr %b next %h want 1 0", bus.pc_write, bus.next_pc); end
    @(negedge clk); #1;
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL wr_fill: valid %b pc %h addr %h want 1 fffffffc 0", bus.if_valid, bus.if_pc, bus.imem_addr); end
  endtask

  // Random stall/redirect/latency; every consumed instruction must continue
  // the program-order stream, which restarts at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc = '0;
    logic [31:0] prev_addr = '0;
    logic        prev_wait = 1'b0;
    int          consumed = 0;
    mem_off = 1'b0; mem_lat = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mem_lat = $urandom_range(0, 3);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc = $urandom & 32'h0000_FFFC;
      #1;
      if (prev_wait) begin
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin n_bad++; $display("FAIL rnd_hold c%0d: req %b addr %h want 1 %h", c, bus.imem_req, bus.imem_addr, prev_addr); end
      end
      if (!bus.pc_write) begin
        n_cmp++; if (bus.next_pc !== pc_q) begin n_bad++; $display("FAIL rnd_next_pc c%0d: got %h want %h", c, bus.next_pc, pc_q); end
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
      else if (bus.if_valid && !bus.stall) begin
        n_cmp++; if (bus.if_pc !== exp_pc || bus.if_instr !== (exp_pc ^ XOR_PAT)) begin n_bad++; $display("FAIL rnd_stream c%0d: pc %h instr %h want %h %h", c, bus.if_pc, bus.if_instr, exp_pc, exp_pc ^ XOR_PAT); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_wait = bus.imem_req && !bus.imem_ready && !bus.redirect_valid;
      prev_addr = bus.imem_addr;
    end
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL rnd_no_err: err %b want 0", bus.fetch_err); end
    n_cmp++; if (consumed < 500) begin n_bad++; $display("FAIL rnd_progress: consumed %0d want >= 500", consumed); end
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_drain();
    test_timeout();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL be the number of consecutive unanswered request cycles that triggers the error state.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc  in  32  current PC from the pc register block.
REQ-005 pc_write  out  1  PC update enable to the pc register block.
REQ-006 next_pc  out  32  PC value loaded when pc_write=1.
REQ-007 stall  in  1  decode cannot accept the fetched instruction this cycle.
REQ-008 redirect_valid  in  1  taken branch or jump from EX.
REQ-009 redirect_pc  in  32  redirect target.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  32  request address.
REQ-012 imem_ready  in  1  memory response valid this cycle; may be high in the same cycle imem_req first rises.
REQ-013 imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
REQ-014 if_valid, if_instr[31:0], if_pc[31:0]  out  IF/ID buffer: valid flag, instruction, and its PC.
REQ-015 fetch_err  out  1  sticky fetch error.

Function
REQ-016 FSM states SHALL be IDLE, REQ, DRAIN and ERR.
REQ-017 IDLE SHALL drive imem_req=0 and SHALL move to REQ after one cycle.
REQ-018 In REQ, imem_req SHALL be (!if_valid || !stall) and imem_addr SHALL be pc.
REQ-019 A response SHALL be accepted in any cycle where imem_req && imem_ready.
REQ-020 On an accepted response without redirect, the controller SHALL drive pc_write=1 and next_pc=pc+4, computed modulo 2^32 (0xFFFFFFFC wraps to 0).
REQ-021 On that response, if_instr<=imem_rdata, if_pc<=pc and if_valid<=1 SHALL take effect on the next edge.
REQ-022 The buffer SHALL be consumed in any cycle where if_valid && !stall; with no new fill that cycle, if_valid<=0.
REQ-023 At most one request SHALL be outstanding; once imem_req rises, it and imem_addr SHALL hold stable until accepted, redirected or reset.
REQ-024 Zero-wait memory with stall=0 SHALL sustain one instruction per cycle.
REQ-025 redirect_valid SHALL have the highest priority: pc_write=1, next_pc=redirect_pc, and if_valid<=0, even when stall=1.
REQ-026 Redirect in a cycle with imem_req=1 and imem_ready=0 SHALL latch the old address into drain_addr and move to DRAIN.
REQ-027 Redirect coinciding with an accepted response SHALL discard that response and remain in REQ.
REQ-028 In DRAIN, imem_req=1 and imem_addr=drain_addr; the response SHALL be discarded (no buffer load, no pc_write), followed by a return to REQ.
REQ-029 Redirect while in DRAIN SHALL update pc again and remain in DRAIN.
REQ-030 redirect_pc[1:0]!=0 SHALL move the FSM to ERR without pc_write.
REQ-031 A timeout counter SHALL increment each cycle imem_req=1 && imem_ready=0 and clear on accept or redirect.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL move to ERR.
REQ-033 ERR SHALL hold fetch_err=1, imem_req=0, pc_write=0 and if_valid=0; only reset exits ERR.
REQ-034 When pc_write=0, next_pc SHALL equal pc.

Reset
REQ-035 While reset=1, all registers SHALL be initialised: state=IDLE, if_valid=0, if_instr=32'h00000013 (NOP), if_pc=0, drain_addr=0, counter=0, fetch_err=0; imem_req=0 and pc_write=0.
REQ-036 Reset asserted mid-request SHALL abandon the request; the memory side SHALL tolerate imem_req dropping without ready.
REQ-037 Reset SHALL override redirect, stall and ready in the same cycle.

Structure
REQ-038 Shared package fetch_pkg SHALL hold the state enum, NOP_INSTR=32'h00000013 and PC_STEP=4.
REQ-039 No sub-module is required; the pc register block SHALL be instantiated beside fetch_ctrl in the parent, not inside it.

Verification
REQ-040 Reset; memory has zero wait and returns addr^0xA5A50000; stall=0 -> if_pc sequence 0,4,8,C from cycle 3, one per cycle, if_instr matching.
REQ-041 Memory has 3 wait states -> imem_addr holds 0x4 for 4 cycles, one pc_write, and if_valid pulses once per 4 cycles.
REQ-042 stall=1 for 5 cycles with if_pc=0x8 -> if_pc/if_instr held, imem_req=0, no pc_write; the fetch of 0xC is issued in the cycle stall falls.
REQ-043 Redirect to 0x100 during the 2nd wait cycle of the 0x10 fetch -> DRAIN; the 0x10 response is dropped; the next imem_addr=0x100; if_pc=0x100 next.
REQ-044 memory never ready with TIMEOUT_CYCLES=8 -> fetch_err=1 after 8 unanswered cycles with imem_req=0; redirect_pc=0x102 -> ERR; reset clears fetch_err.
REQ-045 pc=0xFFFFFFFC with accepted response -> next_pc=0x00000000; redirect coincident with ready -> response discarded, next_pc=redirect_pc.
